// File: rtl/sum_accumulator_pkg.sv
// Shared types and width helpers for the sum accumulator.
// Used by sum_accumulator (optional SUM_ACC_MAX_EN feature lives in the top).
package sum_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Accumulator sized so p_count full-scale sums can never overflow.
  function automatic int acc_width(input int width, input int count);
    return width + 2 + $clog2(count);
  endfunction

  function automatic int cnt_width(input int count);
    return $clog2(count + 1);
  endfunction

endpackage

// File: rtl/sum_accumulator.sv
// Accumulates p_count consecutive adder sums into one block total with valid/ready on both sides.
// Define SUM_ACC_MAX_EN to add the o_w_max port tracking the largest sum of the block.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter  int p_width = 6,
  parameter  int p_count = 4,
  localparam int l_acc_w = acc_width(p_width, p_count),
  localparam int l_cnt_w = cnt_width(p_count)
) (
  input  logic               i_w_clk,
  input  logic               i_w_reset,
  input  logic [p_width+1:0] i_w_s,
  input  logic               i_w_valid,
  output logic               o_w_ready,
  output logic [l_acc_w-1:0] o_w_acc,
  output logic               o_w_acc_valid,
  input  logic               i_w_acc_ready,
  output logic [l_cnt_w-1:0] o_w_count
`ifdef SUM_ACC_MAX_EN
  ,
  output logic [p_width+1:0] o_w_max
`endif
);

  state_t             state;
  logic [l_acc_w-1:0] acc;
  logic [l_cnt_w-1:0] count;
  logic [l_acc_w-1:0] s_ext;
  logic [l_acc_w-1:0] sum_next;
  logic               accept;
  logic               handshake;
  logic               last_accept;

  assign o_w_ready   = (state != ST_DONE) & ~i_w_reset;
  assign accept      = i_w_valid & o_w_ready;
  assign handshake   = o_w_acc_valid & i_w_acc_ready;
  assign s_ext       = l_acc_w'(i_w_s);
  // The first sum of a block reloads the accumulator instead of adding to stale state.
  assign sum_next    = (state == ST_IDLE) ? s_ext : acc + s_ext;
  assign last_accept = (state == ST_ACCUM) && (count == l_cnt_w'(p_count - 1));
  assign o_w_count   = count;

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      state         <= ST_IDLE;
      acc           <= '0;
      count         <= '0;
      o_w_acc       <= '0;
      o_w_acc_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            acc   <= sum_next;
            count <= l_cnt_w'(1);
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            acc   <= sum_next;
            count <= count + l_cnt_w'(1);
            if (last_accept) begin
              state         <= ST_DONE;
              o_w_acc       <= sum_next;
              o_w_acc_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          // o_w_acc is left alone so the sink still sees the last total after the handshake.
          if (handshake) begin
            state         <= ST_IDLE;
            o_w_acc_valid <= 1'b0;
            count         <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SUM_ACC_MAX_EN
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      o_w_max <= '0;
    end else if (accept) begin
      if (state == ST_IDLE || i_w_s > o_w_max) begin
        o_w_max <= i_w_s;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: queue-based block model plus directed literal checks.
// Build with +define+SUM_ACC_MAX_EN to also check o_w_max.
module tb_sum_accumulator;

  localparam int P_WIDTH = 6;
  localparam int P_COUNT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_w_s;
  logic       i_w_valid;
  logic       o_w_ready;
  logic [9:0] o_w_acc;
  logic       o_w_acc_valid;
  logic       i_w_acc_ready;
  logic [2:0] o_w_count;
`ifdef SUM_ACC_MAX_EN
  logic [7:0] o_w_max;
`endif

  int total = 0;
  int bad   = 0;

  // Behavioural model: the sums of the open block sit in a queue; a full queue becomes a total.
  int blk[$];
  bit m_valid = 1'b0;
  int m_acc   = 0;
  int m_cnt   = 0;
  int m_max   = 0;

  sum_accumulator #(
    .p_width(P_WIDTH),
    .p_count(P_COUNT)
  ) dut (
    .i_w_clk      (clk),
    .i_w_reset    (rst),
    .i_w_s        (i_w_s),
    .i_w_valid    (i_w_valid),
    .o_w_ready    (o_w_ready),
    .o_w_acc      (o_w_acc),
    .o_w_acc_valid(o_w_acc_valid),
    .i_w_acc_ready(i_w_acc_ready),
    .o_w_count    (o_w_count)
`ifdef SUM_ACC_MAX_EN
    ,
    .o_w_max      (o_w_max)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    blk.delete();
    m_valid = 1'b0;
    m_acc   = 0;
    m_cnt   = 0;
    m_max   = 0;
  endtask

  task automatic model_step(input bit v, input int s, input bit ar);
    int t;
    if (m_valid) begin
      if (ar) begin
        m_valid = 1'b0;
        m_cnt   = 0;
      end
    end else if (v) begin
      if (blk.size() == 0) m_max = s;
      else if (s > m_max) m_max = s;
      blk.push_back(s);
      m_cnt = blk.size();
      if (blk.size() == P_COUNT) begin
        t = 0;
        foreach (blk[i]) t += blk[i];
        m_acc   = t;
        m_valid = 1'b1;
        blk.delete();
      end
    end
  endtask

  // Compare process: step the model on each rising edge, compare on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst) model_step(i_w_valid, int'(i_w_s), i_w_acc_ready);
      @(negedge clk);
      if (rst) model_reset();
      check("cmp_ready", 32'(o_w_ready), 32'(!m_valid && !rst));
      check("cmp_acc_valid", 32'(o_w_acc_valid), 32'(m_valid));
      check("cmp_count", 32'(o_w_count), 32'(m_cnt));
      check("cmp_acc", 32'(o_w_acc), 32'(m_acc));
`ifdef SUM_ACC_MAX_EN
      check("cmp_max", 32'(o_w_max), 32'(m_max));
`endif
    end
  end

  // Present one sum and hold it until the accepting rising edge has passed.
  task automatic send(input int v);
    int n;
    n = 0;
    i_w_valid = 1'b1;
    i_w_s     = 8'(v);
    @(negedge clk);
    while (!o_w_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout: ready never rose for sum %0d at %0t", v, $time);
    end
    @(posedge clk);
    #1;
    i_w_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    i_w_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_block(input int a, input int b, input int c, input int d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  initial begin
    rst           = 1'b1;
    i_w_valid     = 1'b0;
    i_w_s         = '0;
    i_w_acc_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(o_w_ready), 32'd0);
    check("reset_acc_valid", 32'(o_w_acc_valid), 32'd0);
    check("reset_count", 32'(o_w_count), 32'd0);
    check("reset_acc", 32'(o_w_acc), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back block, valid one cycle after the fourth accept, gone after the handshake.
    send_block(10, 20, 30, 40);
    @(negedge clk);
    check("b2b_acc", 32'(o_w_acc), 32'd100);
    check("b2b_valid", 32'(o_w_acc_valid), 32'd1);
    check("b2b_count", 32'(o_w_count), 32'd4);
    @(negedge clk);
    check("b2b_valid_drop", 32'(o_w_acc_valid), 32'd0);
    check("b2b_acc_hold", 32'(o_w_acc), 32'd100);
    check("b2b_count_clear", 32'(o_w_count), 32'd0);
    idle(1);

    // Full-scale sums.
    send_block(126, 126, 126, 126);
    @(negedge clk);
    check("full_acc", 32'(o_w_acc), 32'd504);
`ifdef SUM_ACC_MAX_EN
    check("full_max", 32'(o_w_max), 32'd126);
`endif
    idle(2);

    // Backpressure in DONE with a sum waiting on the input.
    i_w_acc_ready = 1'b0;
    send_block(1, 1, 1, 1);
    i_w_valid = 1'b1;
    i_w_s     = 8'd77;
    repeat (5) begin
      @(negedge clk);
      check("bp_ready", 32'(o_w_ready), 32'd0);
      check("bp_valid", 32'(o_w_acc_valid), 32'd1);
      check("bp_acc", 32'(o_w_acc), 32'd4);
    end
    @(posedge clk);
    #1;
    i_w_acc_ready = 1'b1;
    send_block(77, 1, 2, 3);
    @(negedge clk);
    check("bp_next_acc", 32'(o_w_acc), 32'd83);
    idle(2);

    // Gapped input, count stepping one per accept.
    for (int k = 1; k <= 4; k++) begin
      send(k);
      @(negedge clk);
      check("gap_count", 32'(o_w_count), 32'(k));
      if (k < 4) idle(3);
    end
    check("gap_acc", 32'(o_w_acc), 32'd10);
    idle(2);

    // Reset mid-block discards the partial block.
    send(3);
    send(4);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_count", 32'(o_w_count), 32'd0);
    check("midrst_acc", 32'(o_w_acc), 32'd0);
    check("midrst_valid", 32'(o_w_acc_valid), 32'd0);
    check("midrst_ready", 32'(o_w_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_block(5, 5, 5, 5);
    @(negedge clk);
    check("postrst_acc", 32'(o_w_acc), 32'd20);
    idle(2);

    // Maximum tracking restarts with each block.
    send_block(7, 90, 3, 12);
    @(negedge clk);
    check("max_blk_acc", 32'(o_w_acc), 32'd112);
`ifdef SUM_ACC_MAX_EN
    check("max_blk_max", 32'(o_w_max), 32'd90);
`endif
    idle(2);
    send_block(1, 1, 1, 1);
    @(negedge clk);
    check("ones_acc", 32'(o_w_acc), 32'd4);
`ifdef SUM_ACC_MAX_EN
    check("ones_max", 32'(o_w_max), 32'd1);
`endif
    idle(2);

    // Random traffic with occasional resets, checked by the model every cycle.
    for (int i = 0; i < 600; i++) begin
      i_w_valid     = ($urandom_range(0, 9) < 6);
      i_w_s         = 8'($urandom_range(0, 255));
      i_w_acc_ready = ($urandom_range(0, 9) < 7);
      rst           = ($urandom_range(0, 199) == 0);
      @(posedge clk);
      #1;
    end
    rst           = 1'b0;
    i_w_acc_ready = 1'b1;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
